// File: rtl/rayid_alloc_pkg.sv
// Shared ray/pixel identifier types and pool-size constants.
// Imported by the rayID allocator, its interface and the testbench.
package rayid_alloc_pkg;

    localparam int NUM_RAYIDS  = 512;
    localparam int RAYID_W     = $clog2(NUM_RAYIDS);
    localparam int PIXELID_W   = 20;

    typedef logic [PIXELID_W-1:0] pixelID_t;
    typedef logic [RAYID_W-1:0]   rayID_t;

    typedef enum logic {
        ST_FRESH   = 1'b0,
        ST_RECYCLE = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/rayid_alloc_if.sv
// Request/retire/status bundle between ray generator, shader and allocator.
// master = client side (requests and frees), slave = allocator side.
interface rayid_alloc_if
    import rayid_alloc_pkg::*;
#(
    parameter int ID_W = RAYID_W
);
    logic            us_valid;
    logic            us_stall;
    logic [ID_W-1:0] alloc_id;
    logic            free_valid;
    logic [ID_W-1:0] free_id;
    logic [ID_W:0]   outstanding;
    logic            idle;
    logic            err;

    modport master (
        output us_valid, free_valid, free_id,
        input  us_stall, alloc_id, outstanding, idle, err
    );

    modport slave (
        input  us_valid, free_valid, free_id,
        output us_stall, alloc_id, outstanding, idle, err
    );
endinterface

// File: rtl/rayid_fifo.sv
// Purpose: single-clock recycle FIFO with same-cycle push/pop and occupancy count.
// Latency: pushed entry visible at head the cycle after the push; head is combinational.
// Backpressure: none; caller guarantees no push when full and no pop when empty.
module rayid_fifo #(
    parameter int DEPTH = 512,
    parameter int W     = 9,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_dat;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/rayid_alloc.sv
// Purpose: rayID pool; hands out fresh IDs 0..NUM_IDS-1 once, then recycles retired IDs. Optional RAYID_ALLOC_CHECK_EN adds an in-use bitmap for double-grant/free detection.
// Latency: zero-cycle grant (alloc_id valid with us_valid & ~us_stall); a retired ID is grantable the next cycle.
// Backpressure: us_stall only when the fresh pool is spent and the recycle FIFO is empty; frees never stall.
module rayid_alloc
    import rayid_alloc_pkg::*;
#(
    parameter int NUM_IDS = NUM_RAYIDS,
    parameter int ID_W    = $clog2(NUM_IDS)
) (
    input logic           clk,
    input logic           rst,
    rayid_alloc_if.slave  bus
);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_IDS - 1);

    alloc_state_t    state_q, state_d;
    logic [ID_W-1:0] fresh_q;
    logic [ID_W:0]   outstanding_q;
    logic            err_q;

    logic            stall;
    logic            grant;
    logic [ID_W-1:0] alloc_id;
    logic            free_ok;
    logic            bad;
    logic            fifo_pop;
    logic [ID_W-1:0] fifo_head;
    logic [ID_W:0]   fifo_count;

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        alloc_id = fresh_q;
        case (state_q)
            ST_FRESH: begin
                stall    = 1'b0;
                alloc_id = fresh_q;
            end
            ST_RECYCLE: begin
                stall    = (fifo_count == '0);
                alloc_id = fifo_head;
            end
            default: begin
                stall    = 1'b0;
                alloc_id = fresh_q;
            end
        endcase
        grant = bus.us_valid & ~stall;
        if (state_q == ST_FRESH && grant && fresh_q == LAST_ID)
            state_d = ST_RECYCLE;
    end

    // A free with nothing outstanding cannot be genuine; drop it instead of polluting the FIFO.
    assign free_ok  = bus.free_valid && (outstanding_q != '0);
    assign fifo_pop = grant && (state_q == ST_RECYCLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_FRESH;
            fresh_q       <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant && state_q == ST_FRESH) fresh_q <= fresh_q + ID_W'(1);
            case ({grant, free_ok})
                2'b10:   outstanding_q <= outstanding_q + (ID_W+1)'(1);
                2'b01:   outstanding_q <= outstanding_q - (ID_W+1)'(1);
                default: outstanding_q <= outstanding_q;
            endcase
            err_q <= err_q | bad;
        end
    end

`ifdef RAYID_ALLOC_CHECK_EN
    logic [NUM_IDS-1:0] in_use_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_use_q <= '0;
        end else begin
            if (free_ok) in_use_q[bus.free_id] <= 1'b0;
            if (grant)   in_use_q[alloc_id]    <= 1'b1;
        end
    end

    assign bad = (bus.free_valid && !free_ok)
              || (free_ok && !in_use_q[bus.free_id])
              || (grant && in_use_q[alloc_id]);
`else
    assign bad = bus.free_valid && !free_ok;
`endif

    rayid_fifo #(
        .DEPTH (NUM_IDS),
        .W     (ID_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (free_ok),
        .push_dat (bus.free_id),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign bus.us_stall    = stall;
    assign bus.alloc_id    = alloc_id;
    assign bus.outstanding = outstanding_q;
    assign bus.idle        = (outstanding_q == '0);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_rayid_alloc.sv
// Bench for rayid_alloc: directed pool-exhaustion/recycle table, error and reset sequences,
// then randomized traffic against a queue-based model of the ID pool.
module tb_rayid_alloc;
    import rayid_alloc_pkg::*;

    localparam int N = 512;
    localparam int W = 9;

    logic clk;
    logic rst;

    rayid_alloc_if #(.ID_W(W)) bus ();

    rayid_alloc #(.NUM_IDS(N), .ID_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit v;
        bit fv;
        int fid;
        bit exp_stall;
        bit chk_alloc;
        int exp_alloc;
        int exp_out;
    } vec_t;

    vec_t tbl[12];

    // Reference model: an unused-fresh counter, a queue of retired IDs, the set of live IDs.
    int m_fresh;
    int m_q[$];
    int m_live[$];
    int m_out;
    bit m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit fv, input int fid);
        bus.us_valid   = v;
        bus.free_valid = fv;
        bus.free_id    = W'(fid);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, int'(bus.us_stall), 0);
        chk({tag, "_alloc"}, int'(bus.alloc_id), 0);
        chk({tag, "_idle"},  int'(bus.idle), 1);
        chk({tag, "_err"},   int'(bus.err), 0);
        chk({tag, "_out"},   int'(bus.outstanding), 0);
    endtask

    // Reset is applied between edges so its asynchronous effect is checked before any clock.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_reset_outputs(tag);
        drive(0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic model_reset();
        m_fresh = 0;
        m_q.delete();
        m_live.delete();
        m_out = 0;
        m_err = 1'b0;
    endtask

    function automatic bit m_stall();
        return (m_fresh >= N) && (m_q.size() == 0);
    endfunction

    function automatic int m_next();
        if (m_fresh < N) return m_fresh;
        if (m_q.size() > 0) return m_q[0];
        return -1;
    endfunction

    task automatic model_step(input bit v, input bit fv, input int fid);
        bit grant;
        int gid;
        int idx;
        grant = v && !m_stall();
        gid   = m_next();
        if (fv) begin
            if (m_out == 0) begin
                m_err = 1'b1;
            end else begin
                idx = -1;
                foreach (m_live[k]) if (m_live[k] == fid && idx < 0) idx = k;
                if (idx >= 0) m_live.delete(idx);
`ifdef RAYID_ALLOC_CHECK_EN
                else m_err = 1'b1;
`endif
            end
        end
        if (grant) begin
            if (m_fresh < N) m_fresh++;
            else void'(m_q.pop_front());
            m_live.push_back(gid);
        end
        if (fv && m_out > 0) m_q.push_back(fid);
        m_out = m_out + (grant ? 1 : 0) - ((fv && m_out > 0) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0);
        #3;
        chk_reset_outputs("por");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Fresh phase: 512 consecutive grants, IDs in order, never stalled.
        for (int i = 0; i < N; i++) begin
            drive(1, 0, 0);
            #1;
            chk("fresh_stall", int'(bus.us_stall), 0);
            chk("fresh_alloc", int'(bus.alloc_id), i);
            chk("fresh_out",   int'(bus.outstanding), i);
            tick();
        end
        drive(0, 0, 0);
        #1;
        chk("full_out",  int'(bus.outstanding), 512);
        chk("full_idle", int'(bus.idle), 0);

        //                v  fv fid stall chkA alloc out
        tbl[0]  = '{1, 0, 0,  1, 0, 0,  512};
        tbl[1]  = '{0, 1, 7,  1, 0, 0,  512};
        tbl[2]  = '{0, 1, 3,  0, 1, 7,  511};
        tbl[3]  = '{1, 0, 0,  0, 1, 7,  510};
        tbl[4]  = '{1, 0, 0,  0, 1, 3,  511};
        tbl[5]  = '{1, 1, 42, 1, 0, 0,  512};
        tbl[6]  = '{1, 0, 0,  0, 1, 42, 511};
        tbl[7]  = '{0, 1, 5,  1, 0, 0,  512};
        tbl[8]  = '{1, 1, 9,  0, 1, 5,  511};
        tbl[9]  = '{0, 0, 0,  0, 1, 9,  511};
        tbl[10] = '{1, 0, 0,  0, 1, 9,  511};
        tbl[11] = '{1, 0, 0,  1, 0, 0,  512};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].fv, tbl[i].fid);
            #1;
            chk($sformatf("tbl%0d_stall", i), int'(bus.us_stall), int'(tbl[i].exp_stall));
            if (tbl[i].chk_alloc)
                chk($sformatf("tbl%0d_alloc", i), int'(bus.alloc_id), tbl[i].exp_alloc);
            chk($sformatf("tbl%0d_out", i), int'(bus.outstanding), tbl[i].exp_out);
            chk($sformatf("tbl%0d_err", i), int'(bus.err), 0);
            tick();
        end
        drive(0, 0, 0);

        // Free with nothing outstanding: ignored, err sticky.
        do_reset("rst_a");
        drive(0, 1, 100);
        tick();
        drive(0, 0, 0);
        #1;
        chk("zero_free_err", int'(bus.err), 1);
        chk("zero_free_out", int'(bus.outstanding), 0);
        chk("zero_free_idle", int'(bus.idle), 1);
        tick();
        tick();
        chk("zero_free_sticky", int'(bus.err), 1);
        drive(1, 0, 0);
        #1;
        chk("zero_free_alloc", int'(bus.alloc_id), 0);

`ifdef RAYID_ALLOC_CHECK_EN
        do_reset("rst_b");
        for (int i = 0; i <= 100; i++) begin
            drive(1, 0, 0);
            tick();
        end
        drive(0, 1, 100);
        tick();
        drive(0, 0, 0);
        #1;
        chk("dbl_free_first_err", int'(bus.err), 0);
        drive(0, 1, 100);
        tick();
        drive(0, 0, 0);
        #1;
        chk("dbl_free_second_err", int'(bus.err), 1);
        tick();
        chk("dbl_free_sticky", int'(bus.err), 1);
`endif

        // Mid-stream reset while granting.
        for (int i = 0; i < 20; i++) begin
            drive(1, (i % 3) == 2, i / 3);
            tick();
        end
        bus.us_valid = 1'b1;
        do_reset("rst_mid");

        // Randomized traffic against the model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit v;
            bit fv;
            int fid;
            v   = ($urandom_range(0, 99) < 60);
            fv  = (m_live.size() > 0) && ($urandom_range(0, 99) < 40);
            fid = 0;
            if (fv) fid = m_live[$urandom_range(0, m_live.size() - 1)];
            drive(v, fv, fid);
            #1;
            chk("rnd_stall", int'(bus.us_stall), int'(m_stall()));
            if (v && !m_stall()) chk("rnd_alloc", int'(bus.alloc_id), m_next());
            chk("rnd_out",  int'(bus.outstanding), m_out);
            chk("rnd_idle", int'(bus.idle), int'(m_out == 0));
            chk("rnd_err",  int'(bus.err), int'(m_err));
            model_step(v, fv, fid);
            tick();
        end
        drive(0, 0, 0);
        #1;
        chk("rnd_final_out", int'(bus.outstanding), m_out);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rayid_alloc.md
RAYID_ALLOC -- requirements
Module: rayid_alloc

Interface
REQ-001 SHALL have parameter NUM_IDS, default 512: size of the rayID pool; power of two, 2..1024.
REQ-002 SHALL have parameter ID_W, default $clog2(NUM_IDS): rayID width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port us_valid, input, 1: upstream (primary ray generator) requests one rayID.
REQ-006 SHALL have port us_stall, output, 1: no rayID grantable this cycle.
REQ-007 SHALL have port alloc_id, output, ID_W: granted rayID; meaningful when us_valid & ~us_stall.
REQ-008 SHALL have port free_valid, input, 1: shader retires a rayID this cycle.
REQ-009 SHALL have port free_id, input, ID_W: rayID being retired.
REQ-010 SHALL have port outstanding, output, ID_W+1: number of rayIDs currently allocated.
REQ-011 SHALL have port idle, output, 1: outstanding == 0, for the rendering_done logic.
REQ-012 SHALL have port err, output, 1: sticky protocol error (see Configuration).

Function
REQ-013 SHALL hold two ID sources: a fresh counter (0..NUM_IDS-1) and a recycle FIFO of depth NUM_IDS.
REQ-014 SHALL implement state machine FRESH -> RECYCLE; FRESH grants the counter value, and the counter increments on each grant.
REQ-015 SHALL transition FRESH -> RECYCLE on the grant of ID NUM_IDS-1; RECYCLE is left only by reset.
REQ-016 In RECYCLE, SHALL grant the FIFO head and pop it on grant.
REQ-017 us_stall SHALL be combinational: 0 in FRESH, and equal to FIFO-empty in RECYCLE.
REQ-018 A grant is us_valid & ~us_stall; alloc_id SHALL be valid in that same cycle with zero latency.
REQ-019 free_valid SHALL always be accepted, with no stall; free_id is pushed into the FIFO that cycle.
REQ-020 SHALL NOT bypass free to alloc: with an empty FIFO and a simultaneous free, us_stall = 1, and the ID is grantable the next cycle.
REQ-021 With a simultaneous grant and free on a non-empty FIFO, SHALL pop and push in the same cycle; FIFO occupancy is unchanged.
REQ-022 outstanding SHALL update by +1 per grant and -1 per free; both together leave it unchanged.
REQ-023 FIFO pointers SHALL wrap modulo NUM_IDS; occupancy SHALL use an ID_W+1 count.
REQ-024 FIFO overflow is impossible by construction (outstanding <= NUM_IDS); a free at outstanding == 0 SHALL be ignored and SHALL set err.

Reset
REQ-025 On rst low, SHALL asynchronously set: state = FRESH, counter = 0, FIFO empty, outstanding = 0, err = 0.
REQ-026 Reset outputs SHALL be: us_stall = 0, alloc_id = 0, idle = 1, err = 0.
REQ-027 Reset mid-render SHALL discard all outstanding IDs; frees arriving after reset deassertion are not expected.

Configuration
REQ-028 Macro RAYID_ALLOC_CHECK_EN defined: SHALL keep an NUM_IDS-bit in-use bitmap, set on grant and cleared on free.
REQ-029 With RAYID_ALLOC_CHECK_EN defined, err SHALL set (sticky) on a free of a not-in-use ID or a grant of an in-use ID.
REQ-030 Macro RAYID_ALLOC_CHECK_EN undefined: no bitmap; err SHALL be driven only by REQ-024.

Structure
REQ-031 The rayID_t typedef (ID_W bits) and the NUM_RAYIDS constant SHALL live in the shared package, next to pixelID_t.
REQ-032 The recycle FIFO SHALL be a sub-module rayid_fifo (synchronous single-clock FIFO with same-cycle push/pop, count output).

Verification
REQ-033 Reset; us_valid held high for 512 cycles -> alloc_id 0..511 in order, us_stall = 0 throughout, outstanding = 512, idle = 0.
REQ-034 After REQ-033: us_valid = 1, no frees -> us_stall = 1; then free IDs 7, 3 -> next grants are 7 then 3.
REQ-035 Pool exhausted; free_id = 42 with us_valid = 1 in the same cycle -> us_stall = 1 that cycle, grant of 42 the next cycle.
REQ-036 FIFO holding {5}; grant and free of 9 in the same cycle -> alloc_id = 5, FIFO = {9}, outstanding unchanged.
REQ-037 With RAYID_ALLOC_CHECK_EN: free 100 twice -> err = 1 on the second free and stays 1; rst low mid-stream -> all reset values from REQ-026 within the same cycle.
